// File: rtl/fpu_pkg.sv
// Shared FP64 format constants, converter state encoding and the integer magnitude helper
// used by the FPU integer/float conversion paths.
package fpu_pkg;

   localparam int FP64_BIAS   = 1023;
   localparam int FP64_EXP_W  = 11;
   localparam int FP64_FRAC_W = 52;
   localparam int CVT_EXP_W   = 12;
   localparam logic [CVT_EXP_W-1:0] CVT_EXP_INIT = 12'(FP64_BIAS + 63);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NORM  = 2'd1,
      ROUND = 2'd2,
      HOLD  = 2'd3
   } cvt_state_t;

   // |x| as an unsigned 64-bit value; -2^63 maps onto 2^63 rather than overflowing
   function automatic logic [63:0] cvt_magnitude(input logic [63:0] x);
      cvt_magnitude = x[63] ? (~x + 64'd1) : x;
   endfunction

endpackage

// File: rtl/fpu_norm_step.sv
// One iteration of leading-one normalisation: coarse-to-fine priority shift of 16, 4 or 1
// bit positions, or done once the MSB is set.
module fpu_norm_step (
   input  logic [63:0] mant_in,
   output logic [63:0] mant_out,
   output logic [4:0]  shamt,
   output logic        done
);

   // first matching rule wins so large zero runs collapse in few iterations
   always_comb begin
      mant_out = mant_in;
      shamt    = 5'd0;
      done     = 1'b0;
      if (mant_in[63:48] == 16'd0) begin
         mant_out = {mant_in[47:0], 16'd0};
         shamt    = 5'd16;
      end else if (mant_in[63:60] == 4'd0) begin
         mant_out = {mant_in[59:0], 4'd0};
         shamt    = 5'd4;
      end else if (mant_in[63] == 1'b0) begin
         mant_out = {mant_in[62:0], 1'b0};
         shamt    = 5'd1;
      end else begin
         done     = 1'b1;
      end
   end

endmodule

// File: rtl/fpu_int_to_fp64.sv
// Multi-cycle signed int64/int32 to binary64 converter with iterative normalisation,
// round-to-nearest-even and valid/ready handshakes on both sides.
module fpu_int_to_fp64
   import fpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        is32,
   input  logic [63:0] src,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] dst
);

   cvt_state_t           state_r, state_s;
   logic                 sign_r, sign_s;
   logic                 is32_r, is32_s;
   logic [63:0]          mant_r, mant_s;
   logic [CVT_EXP_W-1:0] exp_r, exp_s;
   logic [63:0]          dst_r, dst_s;
   logic                 out_valid_r, out_valid_s;
   logic                 in_ready_r, in_ready_s;

   logic [63:0]          src_ext_s;
   logic [63:0]          mag_s;
   logic [63:0]          step_mant_s;
   logic [4:0]           step_shamt_s;
   logic                 step_done_s;
   logic                 round_inc_s;
   logic [FP64_FRAC_W:0] frac_sum_s;
   logic [CVT_EXP_W-1:0] exp_rnd_s;

   assign src_ext_s = is32 ? {{32{src[31]}}, src[31:0]} : src;
   assign mag_s     = cvt_magnitude(src_ext_s);

   fpu_norm_step u_norm_step (
      .mant_in  (mant_r),
      .mant_out (step_mant_s),
      .shamt    (step_shamt_s),
      .done     (step_done_s)
   );

   // guard = mant[10], round/sticky = |mant[9:0], lsb = mant[11]; int32 sources are always exact
   assign round_inc_s = ~is32_r & mant_r[10] & ((|mant_r[9:0]) | mant_r[11]);
   assign frac_sum_s  = {1'b0, mant_r[62:11]} + {{FP64_FRAC_W{1'b0}}, round_inc_s};
   assign exp_rnd_s   = exp_r + {{(CVT_EXP_W-1){1'b0}}, frac_sum_s[FP64_FRAC_W]};

   // next-state and next-datapath decode; flush overrides everything, including an offered operand
   always_comb begin
      state_s     = state_r;
      sign_s      = sign_r;
      is32_s      = is32_r;
      mant_s      = mant_r;
      exp_s       = exp_r;
      dst_s       = dst_r;
      if (flush) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  sign_s = src_ext_s[63];
                  is32_s = is32;
                  mant_s = mag_s;
                  exp_s  = CVT_EXP_INIT;
                  if (mag_s == 64'd0) begin
                     state_s = HOLD;
                     dst_s   = 64'd0;
                  end else begin
                     state_s = NORM;
                  end
               end else begin
                  state_s = IDLE;
               end
            end
            NORM: begin
               if (step_done_s) begin
                  state_s = ROUND;
               end else begin
                  mant_s = step_mant_s;
                  exp_s  = exp_r - {7'd0, step_shamt_s};
               end
            end
            ROUND: begin
               // a fraction carry-out leaves the low 52 sum bits at zero, so no explicit clear
               dst_s   = {sign_r, exp_rnd_s[FP64_EXP_W-1:0], frac_sum_s[FP64_FRAC_W-1:0]};
               state_s = HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  state_s = IDLE;
               end else begin
                  state_s = HOLD;
               end
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end
      out_valid_s = (state_s == HOLD);
      in_ready_s  = (state_s == IDLE);
   end

   // state, datapath and registered handshake outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         sign_r      <= 1'b0;
         is32_r      <= 1'b0;
         mant_r      <= 64'd0;
         exp_r       <= {CVT_EXP_W{1'b0}};
         dst_r       <= 64'd0;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         state_r     <= state_s;
         sign_r      <= sign_s;
         is32_r      <= is32_s;
         mant_r      <= mant_s;
         exp_r       <= exp_s;
         dst_r       <= dst_s;
         out_valid_r <= out_valid_s;
         in_ready_r  <= in_ready_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign dst       = dst_r;

endmodule

// File: tb/tb_fpu_int_to_fp64.sv
// Scoreboard bench for fpu_int_to_fp64: directed spec vectors, latency, backpressure,
// reset/flush aborts and randomised traffic against an arithmetic reference model.
module tb_fpu_int_to_fp64;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        is32 = 1'b0;
   logic [63:0] src = 64'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] dst;

   int          checks = 0;
   int          errors = 0;
   int          pops = 0;
   bit          rand_bp = 1'b0;
   logic [63:0] sbq[$];

   fpu_int_to_fp64 dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .is32      (is32),
      .src       (src),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dst       (dst)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // value-level reference: locate the leading one, keep 53 bits, round the discarded tail
   function automatic logic [63:0] ref_cvt(input logic [63:0] s, input logic i32);
      longint      sv;
      logic [63:0] mag, sig, rem, half;
      logic        neg;
      int          p, sh, e;
      sv  = i32 ? longint'($signed(s[31:0])) : longint'(s);
      neg = (sv < 0);
      mag = neg ? (64'd0 - 64'(sv)) : 64'(sv);
      if (mag == 64'd0) return 64'd0;
      p = 0;
      for (int i = 0; i < 64; i++) if (mag[i]) p = i;
      e = p;
      if (p <= 52) begin
         sig = mag << (52 - p);
      end else begin
         sh   = p - 52;
         sig  = mag >> sh;
         rem  = mag & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && sig[0])) sig = sig + 64'd1;
         if (sig[53]) begin
            sig = sig >> 1;
            e   = p + 1;
         end
      end
      return {neg, 11'(1023 + e), sig[51:0]};
   endfunction

   // offers one operand; returns #1 after the accept edge
   task automatic send(input logic [63:0] s, input logic i32, input logic [63:0] exp, input bit push);
      int n = 0;
      src = s;
      is32 = i32;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
      end else if (push) begin
         sbq.push_back(exp);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out_valid(input string name);
      int n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL %s: out_valid never rose, required 1", name);
      end
   endtask

   // monitor: a handshake seen at the negedge completes on the following rising edge
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (reset_n && !flush && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_output: got dst %h, required no output", dst);
            end else begin
               e = sbq.pop_front();
               chk("dst", dst, e);
               pops++;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [63:0] dsrc [9] = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
                             64'h0020_0000_0000_0001, 64'h0020_0000_0000_0003,
                             64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                             64'hDEAD_BEEF_FFFF_FFFF, 64'h0000_0000_7FFF_FFFF};
   logic        di32 [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [63:0] dexp [9] = '{64'h3FF0_0000_0000_0000, 64'hBFF0_0000_0000_0000, 64'h0,
                             64'h4340_0000_0000_0000, 64'h4340_0000_0000_0002,
                             64'h43E0_0000_0000_0000, 64'hC3E0_0000_0000_0000,
                             64'hBFF0_0000_0000_0000, 64'h41DF_FFFF_FFC0_0000};

   initial begin
      int          n;
      int          p0;
      logic [63:0] r;
      logic        ri;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_dst", dst, 64'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) send(dsrc[i], di32[i], dexp[i], 1'b1);
      repeat (15) @(posedge clk);
      #1;

      // latency from the accept edge to out_valid
      send(64'd1, 1'b0, 64'h3FF0_0000_0000_0000, 1'b1);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency_src1", 64'(n), 64'd11);
      @(posedge clk);
      #1;
      send(64'd0, 1'b0, 64'd0, 1'b1);
      chk("latency_zero", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;

      // backpressure
      out_ready = 1'b0;
      send(64'd5, 1'b0, 64'h4014_0000_0000_0000, 1'b1);
      wait_out_valid("bp_valid");
      p0 = pops;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_dst_stable", dst, 64'h4014_0000_0000_0000);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_release_valid", 64'(out_valid), 64'd0);
      chk("bp_release_ready", 64'(in_ready), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_one_transfer", 64'(pops - p0), 64'd1);

      // asynchronous reset while normalising
      send(64'd1, 1'b0, 64'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_dst", dst, 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      send(64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 64'hC008_0000_0000_0000, 1'b1);
      repeat (15) @(posedge clk);
      #1;

      // flush in HOLD, with a competing operand that must not be taken
      out_ready = 1'b0;
      send(64'd3, 1'b0, 64'd0, 1'b0);
      wait_out_valid("flush_valid");
      flush = 1'b1;
      in_valid = 1'b1;
      src = 64'd7;
      @(posedge clk);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      repeat (12) @(posedge clk);
      #1;
      chk("flush_no_output", 64'(out_valid), 64'd0);
      out_ready = 1'b1;
      send(64'd10, 1'b0, 64'h4024_0000_0000_0000, 1'b1);
      repeat (15) @(posedge clk);
      #1;

      // randomised traffic with backpressure
      rand_bp = 1'b1;
      for (int k = 0; k < 200; k++) begin
         r = {$urandom, $urandom};
         r = r >> $urandom_range(0, 63);
         if ($urandom_range(0, 1) == 1) r = 64'd0 - r;
         case ($urandom_range(0, 9))
            0:       r = 64'd0;
            1:       r = 64'h8000_0000_0000_0000;
            2:       r = {$urandom_range(1, 1023), 1'b1, 52'd0} | 64'd1 << $urandom_range(0, 10);
            default: r = r;
         endcase
         ri = ($urandom_range(0, 3) == 0);
         send(r, ri, ref_cvt(r, ri), 1'b1);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      rand_bp = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
